// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

    // Default operand width used when the divider is not parameterised.
    localparam int DIV_WIDTH_DEFAULT = 16;

    // Control states of the divider.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Width of the iteration counter.
    // It holds values up to WIDTH, so it needs one bit beyond clog2.
    function automatic int div_count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_ctrl.sv
// Control FSM and iteration counter for the divider.
// Emits load, shift and finish strobes for the datapath in seq_divider.
module seq_divider_ctrl
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic src_valid,
    input  logic divisor_zero,
    input  logic dest_ready,
    output logic src_ready,
    output logic dest_valid,
    output logic load,
    output logic shift,
    output logic finish
);

    localparam int CW = div_count_width(WIDTH);

    div_state_t     state;
    div_state_t     state_next;
    logic [CW-1:0]  count;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Iteration counter: cleared on accept, advanced once per quotient bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (shift) begin
            count <= count + CW'(1);
        end
    end

    // Next-state logic and datapath strobes.
    // A zero divisor skips the iteration and goes straight to DONE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (src_valid) begin
                    load       = 1'b1;
                    state_next = divisor_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                shift = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (dest_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign src_ready  = (state == IDLE);
    assign dest_valid = (state == DONE);

endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
// Holds the A/Q/M datapath; sequencing lives in seq_divider_ctrl.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             dest_valid,
    input  logic             dest_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic             load;
    logic             shift;
    logic             finish;
    logic             divisor_zero;

    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;

    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;

    assign divisor_zero = (divisor == '0);

    seq_divider_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .divisor_zero (divisor_zero),
        .dest_ready   (dest_ready),
        .src_ready    (src_ready),
        .dest_valid   (dest_valid),
        .load         (load),
        .shift        (shift),
        .finish       (finish)
    );

    // One restoring step: shift {A,Q} left, trial-subtract M, and keep the
    // difference only when it did not borrow. A stays below M after every
    // step, so its top bit is free to act as the borrow flag.
    always_comb begin
        a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        trial   = a_shift - {1'b0, m_reg};
        a_next  = a_shift;
        q_next  = {q_reg[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            a_next = trial;
            q_next = {q_reg[WIDTH-2:0], 1'b1};
        end
    end

    // Datapath registers: operands latched on accept, iterated while busy.
    // Result registers change only on the zero-divisor accept or the last step,
    // so they hold steady through DONE regardless of operand inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (load) begin
            a_reg <= '0;
            q_reg <= dividend;
            m_reg <= divisor;
            if (divisor_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (shift) begin
            a_reg <= a_next;
            q_reg <= q_next;
            if (finish) begin
                quotient    <= q_next;
                remainder   <= a_next[WIDTH-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider with hand-computed expected results.
module tb_seq_divider;

    localparam int W = 16;
    localparam int MAX_WAIT = 40;

    logic         clk;
    logic         rst;
    logic         src_valid;
    logic         src_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         dest_valid;
    logic         dest_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks;
    int errors;
    int lat;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .dest_valid  (dest_valid),
        .dest_ready  (dest_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Checks the three result outputs together.
    task automatic checkResult(input string tag, input logic [31:0] q,
                               input logic [31:0] r, input logic [31:0] z);
        checkOutput({tag, ".quotient"}, 32'(quotient), q);
        checkOutput({tag, ".remainder"}, 32'(remainder), r);
        checkOutput({tag, ".div_by_zero"}, 32'(div_by_zero), z);
    endtask

    // Presents operands right after an edge and counts edges, starting with the
    // accepting one, until dest_valid is seen; bounded by MAX_WAIT.
    task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                                 output int cycles);
        @(posedge clk);
        #1;
        dividend  = dvd;
        divisor   = dvs;
        src_valid = 1'b1;
        cycles    = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            src_valid = 1'b0;
        end while (!dest_valid && cycles < MAX_WAIT);
    endtask

    // Hands the result to the consumer for exactly one edge.
    task automatic takeResult();
        dest_ready = 1'b1;
        @(posedge clk);
        #1;
        dest_ready = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        src_valid  = 1'b0;
        dest_ready = 1'b0;
        dividend   = '0;
        divisor    = '0;

        // Reset state.
        #2;
        checkOutput("reset.src_ready", 32'(src_ready), 1);
        checkOutput("reset.dest_valid", 32'(dest_valid), 0);
        checkResult("reset", 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;

        // Basic divide and latency.
        applyStimulus(16'd100, 16'd7, lat);
        checkOutput("basic.latency", 32'(lat), 17);
        checkOutput("basic.dest_valid", 32'(dest_valid), 1);
        checkOutput("basic.src_ready", 32'(src_ready), 0);
        checkResult("basic", 14, 2, 0);
        takeResult();
        checkOutput("basic.idle_src_ready", 32'(src_ready), 1);
        checkOutput("basic.idle_dest_valid", 32'(dest_valid), 0);

        // Divide by zero.
        applyStimulus(16'd5, 16'd0, lat);
        checkOutput("dbz.latency", 32'(lat), 1);
        checkOutput("dbz.dest_valid", 32'(dest_valid), 1);
        checkResult("dbz", 32'h0000_FFFF, 5, 1);
        takeResult();

        // Boundaries.
        applyStimulus(16'hFFFF, 16'd1, lat);
        checkOutput("ffff_1.latency", 32'(lat), 17);
        checkResult("ffff_1", 32'h0000_FFFF, 0, 0);
        takeResult();
        applyStimulus(16'd3, 16'd10, lat);
        checkResult("3_10", 0, 3, 0);
        takeResult();
        applyStimulus(16'hFFFF, 16'hFFFF, lat);
        checkResult("ffff_ffff", 1, 0, 0);
        takeResult();
        applyStimulus(16'd0, 16'd9, lat);
        checkResult("0_9", 0, 0, 0);
        takeResult();

        // Backpressure: result must hold while the consumer stalls.
        applyStimulus(16'd1000, 16'd33, lat);
        checkOutput("bp.latency", 32'(lat), 17);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp.hold_dest_valid", 32'(dest_valid), 1);
            checkOutput("bp.hold_src_ready", 32'(src_ready), 0);
            checkResult("bp.hold", 30, 10, 0);
        end
        takeResult();
        checkOutput("bp.release_src_ready", 32'(src_ready), 1);
        checkOutput("bp.release_dest_valid", 32'(dest_valid), 0);

        // New operands offered while busy must be ignored until handoff.
        @(posedge clk);
        #1;
        dividend  = 16'd100;
        divisor   = 16'd7;
        src_valid = 1'b1;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        dividend  = 16'd50;
        divisor   = 16'd5;
        src_valid = 1'b1;
        lat = 0;
        while (!dest_valid && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("busy.dest_valid", 32'(dest_valid), 1);
        checkResult("busy.first", 14, 2, 0);
        dest_ready = 1'b1;
        @(posedge clk);
        #1;
        dest_ready = 1'b0;
        checkOutput("busy.handoff_src_ready", 32'(src_ready), 1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            src_valid = 1'b0;
        end while (!dest_valid && lat < MAX_WAIT);
        checkOutput("busy.second_latency", 32'(lat), 17);
        checkResult("busy.second", 10, 0, 0);
        takeResult();

        // Reset in the middle of an operation.
        @(posedge clk);
        #1;
        dividend  = 16'd200;
        divisor   = 16'd3;
        src_valid = 1'b1;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rstmid.busy_src_ready", 32'(src_ready), 0);
        rst = 1'b1;
        #1;
        checkOutput("rstmid.dest_valid", 32'(dest_valid), 0);
        checkOutput("rstmid.src_ready", 32'(src_ready), 1);
        checkResult("rstmid", 0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        checkOutput("rstmid.after_dest_valid", 32'(dest_valid), 0);
        applyStimulus(16'd77, 16'd7, lat);
        checkOutput("rstmid.latency", 32'(lat), 17);
        checkResult("rstmid.next", 11, 0, 0);
        takeResult();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
